// File: rtl/sram_arbiter.sv
// Shared 512K x 8 SRAM arbiter: fixed-priority grant among CPU, IDE, BIOS and CGA,
// programmable wait states, and a starvation guard that forces a CPU grant.
module sram_arbiter #(
  parameter int WAIT_STATES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clka,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        ide_req,
  input  logic        bios_req,
  input  logic        cga_req,
  input  logic        cpu_we,
  input  logic        ide_we,
  input  logic        bios_we,
  input  logic [18:0] cpu_addr,
  input  logic [18:0] ide_addr,
  input  logic [18:0] bios_addr,
  input  logic [18:0] cga_addr,
  input  logic [7:0]  cpu_din,
  input  logic [7:0]  ide_din,
  input  logic [7:0]  bios_din,
  output logic        cpu_ack,
  output logic        ide_ack,
  output logic        bios_ack,
  output logic        cga_ack,
  output logic [7:0]  rd_data,
  output logic        busy,
  output logic [1:0]  grant,
  output logic [18:0] SRAM_ADDR,
  input  logic [7:0]  SRAM_DATA_i,
  output logic [7:0]  SRAM_DATA_o,
  output logic        SRAM_DATA_oe,
  output logic        SRAM_WE_n
);
  // state  | meaning
  // IDLE   | no access in flight; arbitration and address/data latch happen here
  // ACCESS | strobe phase, WAIT_STATES+1 cycles
  // DONE   | strobe released, write data held, owner acked
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WS_LOAD    = WAIT_STATES[3:0];
  localparam logic [3:0] STARVE_MAX = STARVE_LIMIT[3:0];

  state_t      state_q;
  logic [3:0]  wait_cnt_q;
  logic [3:0]  starve_cnt_q;
  logic        we_q;
  logic [1:0]  grant_q;
  logic [18:0] addr_q;
  logic [7:0]  dout_q;
  logic [7:0]  rd_q;
  logic [3:0]  ack_q;
  logic        busy_q;
  logic        we_n_q;
  logic        oe_q;

  logic        any_req;
  logic [1:0]  grant_d;
  logic [18:0] addr_d;
  logic [7:0]  dout_d;
  logic        we_d;

  always_comb begin
    any_req = cpu_req | ide_req | bios_req | cga_req;
    grant_d = 2'd0;
    if (cpu_req && (starve_cnt_q == STARVE_MAX)) grant_d = 2'd0;
    else if (ide_req)                            grant_d = 2'd1;
    else if (bios_req)                           grant_d = 2'd2;
    else if (cga_req)                            grant_d = 2'd3;
    case (grant_d)
      2'd1:    begin addr_d = ide_addr;  dout_d = ide_din;  we_d = ide_we;  end
      2'd2:    begin addr_d = bios_addr; dout_d = bios_din; we_d = bios_we; end
      2'd3:    begin addr_d = cga_addr;  dout_d = 8'h00;    we_d = 1'b0;    end
      default: begin addr_d = cpu_addr;  dout_d = cpu_din;  we_d = cpu_we;  end
    endcase
  end

  always_ff @(posedge clka or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 4'd0;
      starve_cnt_q <= 4'd0;
      we_q         <= 1'b0;
      grant_q      <= 2'd0;
      addr_q       <= 19'd0;
      dout_q       <= 8'd0;
      rd_q         <= 8'd0;
      ack_q        <= 4'd0;
      busy_q       <= 1'b0;
      we_n_q       <= 1'b1;
      oe_q         <= 1'b0;
    end else begin
      ack_q <= 4'd0;
      case (state_q)
        IDLE: begin
          if (!cpu_req) starve_cnt_q <= 4'd0;
          if (any_req) begin
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            dout_q     <= dout_d;
            we_q       <= we_d;
            wait_cnt_q <= WS_LOAD;
            we_n_q     <= ~we_d;
            oe_q       <= we_d;
            busy_q     <= 1'b1;
            state_q    <= ACCESS;
            if (grant_d == 2'd0)
              starve_cnt_q <= 4'd0;
            else if (cpu_req && (starve_cnt_q != STARVE_MAX))
              starve_cnt_q <= starve_cnt_q + 4'd1;
          end
        end
        ACCESS: begin
          if (wait_cnt_q == 4'd0) begin
            if (!we_q) rd_q <= SRAM_DATA_i;
            we_n_q         <= 1'b1;
            ack_q[grant_q] <= 1'b1;
            state_q        <= DONE;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        DONE: begin
          oe_q    <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_ack      = ack_q[0];
  assign ide_ack      = ack_q[1];
  assign bios_ack     = ack_q[2];
  assign cga_ack      = ack_q[3];
  assign rd_data      = rd_q;
  assign busy         = busy_q;
  assign grant        = grant_q;
  assign SRAM_ADDR    = addr_q;
  assign SRAM_DATA_o  = dout_q;
  assign SRAM_DATA_oe = oe_q;
  assign SRAM_WE_n    = we_n_q;
endmodule
